// File: rtl/circ_fifo_pkg.sv
// Shared helpers for the parametrised circular FIFO: width helpers, wrap-aware
// pointer increment, operation encoding and sticky error flag bit positions.
package circ_fifo_pkg;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UDF  = 1;
  localparam int NUM_FLAGS = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit compare so DEPTH need not be a power of two.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/circ_fifo_if.sv
// Producer/consumer handshake bundle for circ_fifo_param; master drives requests,
// slave is the FIFO.
interface circ_fifo_if
  import circ_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = cnt_width(DEPTH);

  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, data_in, pop, clr_err,
    input  data_out, out_valid, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, clr_err,
    output data_out, out_valid, empty, full, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/circ_fifo_ctrl.sv
// Pointer, occupancy and accept/error control for circ_fifo_param.
// Build option: CIRC_FIFO_OVERWRITE_EN makes a push into a full FIFO replace the oldest word.
module circ_fifo_ctrl
  import circ_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW       = cnt_width(DEPTH),
  parameter int PW       = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic          wr_en,
  output logic          rd_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [NUM_FLAGS-1:0] err_q, err_d;
  logic [NUM_FLAGS-1:0] err_evt;
  logic                 rd_adv;
  op_e                  op;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign op          = op_e'({push, pop});

  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_adv  = 1'b0;
    err_evt = '0;
    count_d = count_q;
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          wr_en   = 1'b1;
          count_d = count_q + ONE_C;
        end else begin
          err_evt[FLAG_OVF] = 1'b1;
`ifdef CIRC_FIFO_OVERWRITE_EN
          // Oldest slot is rewritten; read side skips past it without producing output.
          wr_en  = 1'b1;
          rd_adv = 1'b1;
`endif
        end
      end
      OP_POP: begin
        if (!empty) begin
          rd_en   = 1'b1;
          rd_adv  = 1'b1;
          count_d = count_q - ONE_C;
        end else begin
          err_evt[FLAG_UDF] = 1'b1;
        end
      end
      OP_BOTH: begin
        // No bypass when empty: the pop is rejected and only the write lands.
        wr_en = 1'b1;
        if (empty) begin
          err_evt[FLAG_UDF] = 1'b1;
          count_d           = ONE_C;
        end else begin
          rd_en  = 1'b1;
          rd_adv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (rd_adv) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
    // A fresh error in the clearing cycle keeps its flag set.
    err_d = err_evt | (clr_err ? '0 : err_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;
  assign overflow  = err_q[FLAG_OVF];
  assign underflow = err_q[FLAG_UDF];

endmodule

// File: rtl/circ_fifo_param.sv
// Parametrised single-clock circular FIFO: storage array and registered read port.
// Build option: CIRC_FIFO_OVERWRITE_EN (overwrite oldest entry on push while full).
module circ_fifo_param
  import circ_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic        clk,
  input  logic        reset,
  circ_fifo_if.slave  bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             wr_en, rd_en;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  circ_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .CW       (CW),
    .PW       (PW)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .push        (bus.push),
    .pop         (bus.pop),
    .clr_err     (bus.clr_err),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .empty       (bus.empty),
    .full        (bus.full),
    .almost_full (bus.almost_full),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= bus.data_in;
  end

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = rd_en;
    if (rd_en) data_out_d = mem_q[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count;

endmodule

// File: tb/tb_circ_fifo_param.sv
// Directed bench for circ_fifo_param: a DEPTH=8 instance for the main scenarios and
// a DEPTH=5 instance for non-power-of-two wrap. Honours CIRC_FIFO_OVERWRITE_EN.
module tb_circ_fifo_param;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  circ_fifo_if #(.WIDTH(8), .DEPTH(8)) f8 ();
  circ_fifo_if #(.WIDTH(8), .DEPTH(5)) f5 ();

  circ_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (f8.slave)
  );

  circ_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (f5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Apply one cycle of stimulus to the DEPTH=8 instance, then settle past the edge.
  task automatic op8(input logic psh, input logic pp, input logic [7:0] din, input logic clr);
    f8.push = psh; f8.pop = pp; f8.data_in = din; f8.clr_err = clr;
    @(posedge clk); #1;
    f8.push = 1'b0; f8.pop = 1'b0; f8.clr_err = 1'b0;
  endtask

  task automatic op5(input logic psh, input logic pp, input logic [7:0] din);
    f5.push = psh; f5.pop = pp; f5.data_in = din; f5.clr_err = 1'b0;
    @(posedge clk); #1;
    f5.push = 1'b0; f5.pop = 1'b0;
  endtask

  initial begin
    logic [7:0] last;
    n_chk = 0; n_pass = 0;
    reset = 1'b0;
    f8.push = 1'b0; f8.pop = 1'b0; f8.data_in = '0; f8.clr_err = 1'b0;
    f5.push = 1'b0; f5.pop = 1'b0; f5.data_in = '0; f5.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(f8.count), 0);
    chk("rst_empty", 32'(f8.empty), 1);
    chk("rst_full", 32'(f8.full), 0);
    chk("rst_af", 32'(f8.almost_full), 0);
    chk("rst_dout", 32'(f8.data_out), 0);
    chk("rst_vld", 32'(f8.out_valid), 0);
    chk("rst_ovf", 32'(f8.overflow), 0);
    chk("rst_udf", 32'(f8.underflow), 0);
    reset = 1'b1;

    // Fill 0x01..0x08; almost_full from count 7.
    for (int i = 1; i <= 8; i++) begin
      op8(1'b1, 1'b0, 8'(i), 1'b0);
      chk("fill_count", 32'(f8.count), 32'(i));
      chk("fill_af", 32'(f8.almost_full), (i >= 7) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(f8.full), 1);

    op8(1'b1, 1'b0, 8'h09, 1'b0);
    chk("ovf_flag", 32'(f8.overflow), 1);
    chk("ovf_count", 32'(f8.count), 8);
    chk("ovf_full", 32'(f8.full), 1);

    for (int i = 1; i <= 8; i++) begin
      op8(1'b0, 1'b1, 8'h00, 1'b0);
`ifdef CIRC_FIFO_OVERWRITE_EN
      chk("drain_data", 32'(f8.data_out), 32'(i + 1));
`else
      chk("drain_data", 32'(f8.data_out), 32'(i));
`endif
      chk("drain_vld", 32'(f8.out_valid), 1);
    end
    chk("drain_empty", 32'(f8.empty), 1);
`ifdef CIRC_FIFO_OVERWRITE_EN
    last = 8'h09;
`else
    last = 8'h08;
`endif

    op8(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_flag", 32'(f8.underflow), 1);
    chk("udf_vld", 32'(f8.out_valid), 0);
    chk("udf_dout", 32'(f8.data_out), 32'(last));
    chk("udf_ovf_sticky", 32'(f8.overflow), 1);
    op8(1'b0, 1'b1, 8'h00, 1'b1);
    chk("clr_vs_new_udf", 32'(f8.underflow), 1);
    chk("clr_ovf", 32'(f8.overflow), 0);
    op8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_udf", 32'(f8.underflow), 0);

    // Simultaneous push/pop at count 0, 4, 8.
    op8(1'b1, 1'b1, 8'hA0, 1'b0);
    chk("pp0_count", 32'(f8.count), 1);
    chk("pp0_udf", 32'(f8.underflow), 1);
    chk("pp0_vld", 32'(f8.out_valid), 0);
    op8(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 3; i++) op8(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    op8(1'b1, 1'b1, 8'hA4, 1'b0);
    chk("pp4_count", 32'(f8.count), 4);
    chk("pp4_data", 32'(f8.data_out), 32'hA0);
    chk("pp4_udf", 32'(f8.underflow), 0);
    for (int i = 5; i <= 8; i++) op8(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    op8(1'b1, 1'b1, 8'hA9, 1'b0);
    chk("pp8_count", 32'(f8.count), 8);
    chk("pp8_data", 32'(f8.data_out), 32'hA1);
    chk("pp8_ovf", 32'(f8.overflow), 0);
    chk("pp8_udf", 32'(f8.underflow), 0);
    for (int i = 2; i <= 9; i++) begin
      op8(1'b0, 1'b1, 8'h00, 1'b0);
      chk("pp_order", 32'(f8.data_out), 32'(8'hA0 + i));
    end
    chk("pp_empty", 32'(f8.empty), 1);

    // Mid-stream reset with count=3 and a flag set.
    op8(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) op8(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    op8(1'b0, 1'b1, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(f8.count), 3);
    chk("pre_rst_dout", 32'(f8.data_out), 32'hC0);
    chk("pre_rst_udf", 32'(f8.underflow), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(f8.count), 0);
    chk("mid_rst_empty", 32'(f8.empty), 1);
    chk("mid_rst_dout", 32'(f8.data_out), 0);
    chk("mid_rst_udf", 32'(f8.underflow), 0);
    #1 reset = 1'b1;
    op8(1'b1, 1'b0, 8'h55, 1'b0);
    chk("post_rst_count", 32'(f8.count), 1);
    op8(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_data", 32'(f8.data_out), 32'h55);

    // DEPTH=5: fill, 13 push/pop pairs at full, then drain.
    for (int i = 0; i < 5; i++) op5(1'b1, 1'b0, 8'(8'h10 + i));
    chk("d5_full", 32'(f5.full), 1);
    chk("d5_count", 32'(f5.count), 5);
    for (int j = 0; j < 13; j++) begin
      op5(1'b1, 1'b1, 8'(8'h15 + j));
      chk("d5_pair_data", 32'(f5.data_out), 32'(8'h10 + j));
      chk("d5_pair_count", 32'(f5.count), 5);
    end
    chk("d5_ovf", 32'(f5.overflow), 0);
    for (int k = 0; k < 5; k++) begin
      op5(1'b0, 1'b1, 8'h00);
      chk("d5_drain", 32'(f5.data_out), 32'(8'h1D + k));
    end
    chk("d5_empty", 32'(f5.empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
